mips_control_unit: RTL

- Multicycle MIPS control FSM that drives every control input of the datapath: PC, memory, IR, register file, A/B, ALU, ALUOut, MDR and EPC.
- Consumes the decoded Opcode/Funct fields and the ALU flags.
- Produces one-hot-free control strobes, plus the 8-bit state code `Estado` that the datapath exports for debug.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_control_unit_if.sv | 34 +++
 rtl/mips_alu_decode.sv | 15 +
 rtl/mips_control_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state codes, opcode/funct fields and mux/ALU encodings for the MIPS control unit
package mips_ctrl_pkg;
    typedef enum logic [7:0] {
        RESET      = 8'h00,
        FETCH      = 8'h01,
        FETCH_DONE = 8'h02,
        DECODE     = 8'h03,
        R_EXEC     = 8'h04,
        R_WB       = 8'h05,
        ADDI_EXEC  = 8'h06,
        I_WB       = 8'h07,
        MEM_ADDR   = 8'h08,
        MEM_READ   = 8'h09,
        MEM_WB     = 8'h0A,
        MEM_WRITE  = 8'h0B,
        BRANCH     = 8'h0C,
        JUMP       = 8'h0D,
        EXCEPTION  = 8'h0E,
        EXC_JUMP   = 8'h0F,
        MULT_RUN   = 8'h10,
        MULT_DONE  = 8'h11,
        MF_WB      = 8'h12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_XOR = 6'h26;
`ifdef MIPS_MULT_EN
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
`endif

    localparam logic [2:0] ALU_LOAD = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;
endpackage

// File: rtl/mips_control_unit_if.sv
// mips_control_unit_if: datapath <-> control bundle; master is the control unit, slave the datapath
interface mips_control_unit_if;
    logic [5:0] Opcode, Funct;
    logic       Zero, Overflow;
    logic       PC_load, PC_cond;
    logic [1:0] PCSource;
    logic       IorD, wr, IRWrite, MDR_load, RegWrite, RegDst, MemtoReg;
    logic       A_load, B_load, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       AluOut_load, EPC_load;
    logic [7:0] Estado;
`ifdef MIPS_MULT_EN
    logic       mul_start, mul_done;
`endif

    modport master (
        input  Opcode, Funct, Zero, Overflow,
        output PC_load, PC_cond, PCSource, IorD, wr, IRWrite, MDR_load, RegWrite, RegDst, MemtoReg,
               A_load, B_load, ALUSrcA, ALUSrcB, ALUOp, AluOut_load, EPC_load, Estado
`ifdef MIPS_MULT_EN
        , input mul_done, output mul_start
`endif
    );

    modport slave (
        output Opcode, Funct, Zero, Overflow,
        input  PC_load, PC_cond, PCSource, IorD, wr, IRWrite, MDR_load, RegWrite, RegDst, MemtoReg,
               A_load, B_load, ALUSrcA, ALUSrcB, ALUOp, AluOut_load, EPC_load, Estado
`ifdef MIPS_MULT_EN
        , output mul_done, input mul_start
`endif
    );
endinterface

// File: rtl/mips_alu_decode.sv
// mips_alu_decode: maps Opcode/Funct to the ula32 function code for the execute states
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o
);
    always_comb
        alu_op_o = opcode_i != OP_RTYPE ? ALU_ADD :
                   funct_i == F_ADD     ? ALU_ADD :
                   funct_i == F_SUB     ? ALU_SUB :
                   funct_i == F_AND     ? ALU_AND :
                   funct_i == F_XOR     ? ALU_XOR : ALU_LOAD;
endmodule

// File: rtl/mips_control_unit.sv
// mips_control_unit: multicycle MIPS control FSM with Moore strobes and Estado debug code.
// Define MIPS_MULT_EN to add the mult/mfhi/mflo states and the mul_start/mul_done handshake.
module mips_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT          = 1,
    parameter bit EXC_OPCODE_EN_BIT = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    mips_control_unit_if.master bus
);
    localparam state_t BAD = EXC_OPCODE_EN_BIT ? EXCEPTION : FETCH;

    state_t     state_q, state_d, dispatch;
    logic [2:0] cnt_q, cnt_d, r_alu_op;
    logic       ovf_q, ovf_d, r_arith, r_valid;
`ifdef MIPS_MULT_EN
    logic       run_q;
`endif

    mips_alu_decode u_alu_decode (.opcode_i(bus.Opcode), .funct_i(bus.Funct), .alu_op_o(r_alu_op));

    assign r_arith = bus.Funct == F_ADD || bus.Funct == F_SUB;
    assign r_valid = r_arith || bus.Funct == F_AND || bus.Funct == F_XOR;
    // any state change reloads the counter; only the memory states consume it
    assign cnt_d   = state_d != state_q ? 3'(MEM_WAIT) : cnt_q - {2'b00, |cnt_q};
    assign ovf_d   = state_q == R_EXEC    ? bus.Overflow & r_arith :
                     state_q == ADDI_EXEC ? bus.Overflow : ovf_q;

    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) begin
            state_q <= RESET;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end

`ifdef MIPS_MULT_EN
    always_ff @(posedge Clk or negedge Reset)
        if (!Reset) run_q <= 1'b0;
        else        run_q <= state_q == MULT_RUN;
    assign bus.mul_start = state_q == MULT_RUN && !run_q;
`endif

    always_comb begin
        dispatch = BAD;
        case (bus.Opcode)
            OP_RTYPE:      dispatch = r_valid ? R_EXEC : BAD;
            OP_LW, OP_SW:  dispatch = MEM_ADDR;
            OP_BEQ, OP_BNE: dispatch = BRANCH;
            OP_J:          dispatch = JUMP;
            OP_ADDI:       dispatch = ADDI_EXEC;
            default:       ;
        endcase
`ifdef MIPS_MULT_EN
        if (bus.Opcode == OP_RTYPE && bus.Funct == F_MULT) dispatch = MULT_RUN;
        if (bus.Opcode == OP_RTYPE && (bus.Funct == F_MFHI || bus.Funct == F_MFLO)) dispatch = MF_WB;
`endif
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:      state_d = cnt_q == 3'd0 ? FETCH_DONE : FETCH;
            FETCH_DONE: state_d = DECODE;
            DECODE:     state_d = dispatch;
            R_EXEC:     state_d = R_WB;
            ADDI_EXEC:  state_d = I_WB;
            R_WB, I_WB: state_d = ovf_q ? EXCEPTION : FETCH;
            MEM_ADDR:   state_d = bus.Opcode == OP_SW ? MEM_WRITE : MEM_READ;
            MEM_READ:   state_d = cnt_q == 3'd0 ? MEM_WB : MEM_READ;
            MEM_WRITE:  state_d = cnt_q == 3'd0 ? FETCH : MEM_WRITE;
            EXCEPTION:  state_d = EXC_JUMP;
`ifdef MIPS_MULT_EN
            MULT_RUN:   state_d = bus.mul_done ? MULT_DONE : MULT_RUN;
`endif
            default:    state_d = FETCH;
        endcase
    end

    always_comb begin
        bus.PC_load     = 1'b0;
        bus.PC_cond     = 1'b0;
        bus.PCSource    = PCS_ALU;
        bus.IorD        = 1'b0;
        bus.wr          = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MDR_load    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.A_load      = 1'b0;
        bus.B_load      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = ALU_LOAD;
        bus.AluOut_load = 1'b0;
        bus.EPC_load    = 1'b0;
        bus.Estado      = state_q;
        case (state_q)
            FETCH_DONE: begin
                bus.IRWrite = 1'b1;
                bus.PC_load = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = ALU_ADD;
            end
            DECODE: begin
                bus.A_load      = 1'b1;
                bus.B_load      = 1'b1;
                bus.ALUSrcB     = 2'b11;
                bus.ALUOp       = ALU_ADD;
                bus.AluOut_load = 1'b1;
            end
            R_EXEC, ADDI_EXEC, MEM_ADDR: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = state_q == R_EXEC ? 2'b00 : 2'b10;
                bus.ALUOp       = state_q == MEM_ADDR ? ALU_ADD : r_alu_op;
                bus.AluOut_load = 1'b1;
            end
            R_WB, I_WB: begin
                bus.RegDst   = state_q == R_WB;
                bus.RegWrite = !ovf_q;
            end
            MEM_READ: begin
                bus.IorD     = 1'b1;
                bus.MDR_load = cnt_q == 3'd0;
            end
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEM_WRITE: begin
                bus.IorD = 1'b1;
                bus.wr   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = ALU_SUB;
                bus.PC_cond  = (bus.Opcode == OP_BNE) ^ bus.Zero;
                bus.PCSource = PCS_ALUOUT;
            end
            JUMP: begin
                bus.PC_load  = 1'b1;
                bus.PCSource = PCS_JUMP;
            end
            EXCEPTION: begin
                bus.ALUSrcB  = 2'b01;
                bus.ALUOp    = ALU_SUB;
                bus.EPC_load = 1'b1;
            end
            EXC_JUMP: begin
                bus.PC_load  = 1'b1;
                bus.PCSource = PCS_EXC;
            end
`ifdef MIPS_MULT_EN
            MF_WB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule
